// File: rtl/sparse_pe_stream_if.sv
// Stream bundle for one sparse processing element: top/left inputs,
// systolic forwards to bottom/right, and the result/status outputs.
interface sparse_pe_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_SIZE = 3
);
  logic                  up_valid, up_last;
  logic [DATA_WIDTH-1:0] up_data;
  logic [INDEX_SIZE-1:0] up_idx;
  logic                  left_valid, left_last;
  logic [DATA_WIDTH-1:0] left_data;
  logic [INDEX_SIZE-1:0] left_idx;
  logic                  down_valid, down_last;
  logic [DATA_WIDTH-1:0] down_data;
  logic [INDEX_SIZE-1:0] down_idx;
  logic                  right_valid, right_last;
  logic [DATA_WIDTH-1:0] right_data;
  logic [INDEX_SIZE-1:0] right_idx;
  logic [DATA_WIDTH-1:0] result;
  logic                  result_valid, busy, overflow;

  modport master (
    output up_valid, up_last, up_data, up_idx,
    output left_valid, left_last, left_data, left_idx,
    input  down_valid, down_last, down_data, down_idx,
    input  right_valid, right_last, right_data, right_idx,
    input  result, result_valid, busy, overflow
  );

  modport slave (
    input  up_valid, up_last, up_data, up_idx,
    input  left_valid, left_last, left_data, left_idx,
    output down_valid, down_last, down_data, down_idx,
    output right_valid, right_last, right_data, right_idx,
    output result, result_valid, busy, overflow
  );
endinterface

// File: rtl/sparse_pe_stream.sv
// Sparse dot-product PE: intersects two index-ascending element streams,
// buffering unmatched elements per side, and emits a saturated result.
// Side 0 = up (column stream), side 1 = left (row stream).
module sparse_pe_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int INDEX_SIZE = 3,
  parameter int DEPTH      = 4,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+INDEX_SIZE
) (
  input logic              clk,
  input logic              rst,
  sparse_pe_stream_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef struct packed {
    logic [INDEX_SIZE-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                        r_state, w_next;
  logic signed [ACC_WIDTH-1:0]   r_acc, w_acc_next;
  ent_t        [DEPTH-1:0]       r_buf [2];
  logic        [DEPTH-1:0]       r_bv  [2];
  ent_t        [DEPTH-1:0]       w_nbuf[2];
  logic        [DEPTH-1:0]       w_nbv [2];
  logic        [DEPTH-1:0]       w_keep[2];
  logic        [DEPTH-1:0]       w_clr [2];
  logic        [INDEX_SIZE-1:0]  r_latest[2];
  logic        [1:0]             r_seen, r_lastf;
  logic        [DATA_WIDTH-1:0]  r_result;
  logic                          r_rv, r_ovf;
  logic        [1:0]             w_in_v, w_in_last, w_acc, w_hit, w_ins, w_ovf_ev, w_last_done;
  logic        [INDEX_SIZE-1:0]  w_in_idx[2];
  logic        [DATA_WIDTH-1:0]  w_in_data[2], w_hit_data[2];
  logic                          w_same, w_done, w_load;

  // Fixed-point product: full-width multiply, arithmetic shift (floor), sign-extend.
  function automatic logic signed [ACC_WIDTH-1:0] f_delta(input logic [DATA_WIDTH-1:0] a,
                                                          input logic [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    p = p >>> FRAC_BITS;
    return ACC_WIDTH'(p);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_sat(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return a[DATA_WIDTH-1:0];
  endfunction

  // Match/buffer datapath: same-cycle match, opposite-buffer lookup, pruning, insertion.
  always_comb begin : p_datapath
    logic pre, cur;
    w_in_v      = {bus.left_valid, bus.up_valid};
    w_in_last   = {bus.left_last, bus.up_last};
    w_in_idx[0] = bus.up_idx;   w_in_idx[1]  = bus.left_idx;
    w_in_data[0] = bus.up_data; w_in_data[1] = bus.left_data;
    w_acc  = (r_state != DONE) ? w_in_v : 2'b00;
    w_same = w_acc[0] && w_acc[1] && (bus.up_idx == bus.left_idx);
    w_hit = '0; w_ins = '0; w_ovf_ev = '0; w_last_done = '0;
    pre = 1'b0; cur = 1'b0;
    for (int s = 0; s < 2; s++) begin
      w_hit_data[s] = '0;
      w_clr[s]      = '0;
    end
    // Lookup of each accepted element in the opposite side's buffer.
    for (int s = 0; s < 2; s++) begin
      if (w_acc[s] && !w_same) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!w_hit[s] && r_bv[s^1][i] && r_buf[s^1][i].idx == w_in_idx[s]) begin
            w_hit[s]        = 1'b1;
            w_hit_data[s]   = r_buf[s^1][i].data;
            w_clr[s^1][i]   = 1'b1;
          end
        end
      end
    end
    // Entries surviving matches and pruning; unmatched element shifts in at slot 0,
    // pushing only the contiguous valid prefix so age order is kept by position.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++)
        w_keep[s][i] = r_bv[s][i] && !w_clr[s][i] &&
                       !(r_seen[s^1] && (r_buf[s][i].idx < r_latest[s^1]));
      w_ins[s]    = w_acc[s] && !w_same && !w_hit[s];
      w_ovf_ev[s] = w_ins[s] && (&w_keep[s]);
      w_nbuf[s]   = r_buf[s];
      w_nbv[s]    = w_keep[s];
      if (w_ins[s]) begin
        w_nbuf[s][0] = '{idx: w_in_idx[s], data: w_in_data[s]};
        w_nbv[s][0]  = 1'b1;
        pre = w_keep[s][0];
        for (int i = 1; i < DEPTH; i++) begin
          cur = pre;
          pre = pre & w_keep[s][i];
          if (cur) begin
            w_nbuf[s][i] = r_buf[s][i-1];
            w_nbv[s][i]  = 1'b1;
          end
        end
      end
      w_last_done[s] = r_lastf[s] || (w_acc[s] && w_in_last[s]);
    end
    w_acc_next = r_acc;
    if (w_same)   w_acc_next = w_acc_next + f_delta(bus.up_data, bus.left_data);
    if (w_hit[0]) w_acc_next = w_acc_next + f_delta(bus.up_data, w_hit_data[0]);
    if (w_hit[1]) w_acc_next = w_acc_next + f_delta(w_hit_data[1], bus.left_data);
    w_done = &w_last_done;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE:    if (|w_in_v) w_next = w_done ? DONE : ACCUM;
      ACCUM:   if (w_done)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_next == DONE && r_state != DONE) w_load = 1'b1;
  end

  // State, accumulator, buffers, forwards and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_seen   <= '0;
      r_lastf  <= '0;
      r_result <= '0;
      r_rv     <= 1'b0;
      r_ovf    <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        r_buf[s]    <= '0;
        r_bv[s]     <= '0;
        r_latest[s] <= '0;
      end
      bus.down_valid  <= 1'b0; bus.down_last  <= 1'b0; bus.down_data  <= '0; bus.down_idx  <= '0;
      bus.right_valid <= 1'b0; bus.right_last <= 1'b0; bus.right_data <= '0; bus.right_idx <= '0;
    end else begin
      bus.down_valid  <= bus.up_valid;   bus.down_last  <= bus.up_last;
      bus.down_data   <= bus.up_data;    bus.down_idx   <= bus.up_idx;
      bus.right_valid <= bus.left_valid; bus.right_last <= bus.left_last;
      bus.right_data  <= bus.left_data;  bus.right_idx  <= bus.left_idx;
      r_state <= w_next;
      r_rv    <= w_load;
      if (w_load) r_result <= f_sat(w_acc_next);
      if (|w_ovf_ev) r_ovf <= 1'b1;
      if (r_state == DONE) begin
        r_acc   <= '0;
        r_seen  <= '0;
        r_lastf <= '0;
        for (int s = 0; s < 2; s++) begin
          r_buf[s]    <= '0;
          r_bv[s]     <= '0;
          r_latest[s] <= '0;
        end
      end else begin
        r_acc <= w_acc_next;
        for (int s = 0; s < 2; s++) begin
          r_buf[s] <= w_nbuf[s];
          r_bv[s]  <= w_nbv[s];
          if (w_acc[s]) begin
            r_seen[s]   <= 1'b1;
            r_latest[s] <= w_in_idx[s];
            if (w_in_last[s]) r_lastf[s] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.result       = r_result;
  assign bus.result_valid = r_rv;
  assign bus.busy         = (r_state != IDLE);
  assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_sparse_pe_stream.sv
// Directed bench for sparse_pe_stream: dense, sparse, saturation, rounding,
// overflow, reset-abort and back-to-back operations with hand-computed results.
module tb_sparse_pe_stream;
  localparam int DW = 8;
  localparam int IS = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  sparse_pe_stream_if #(.DATA_WIDTH(DW), .INDEX_SIZE(IS)) bus ();

  sparse_pe_stream #(.DATA_WIDTH(DW), .FRAC_BITS(4), .INDEX_SIZE(IS), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just after the edge.
  task automatic step(input logic uv, input logic ul, input int ud, input int ui,
                      input logic lv, input logic ll, input int ld, input int li);
    bus.up_valid   = uv; bus.up_last   = ul; bus.up_data   = ud[DW-1:0]; bus.up_idx   = ui[IS-1:0];
    bus.left_valid = lv; bus.left_last = ll; bus.left_data = ld[DW-1:0]; bus.left_idx = li[IS-1:0];
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int sres();
    return int'($signed(bus.result));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    idle();
    chk("rst_result", sres(), 0);
    chk("rst_rv", int'(bus.result_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_down_valid", int'(bus.down_valid), 0);
    rst = 1'b0;
    idle();

    // Dense: idx 0..3 both sides, 1.0 * 1.0 each -> 4.0 = 64
    step(1, 0, 16, 0, 1, 0, 16, 0);
    chk("dense_busy", int'(bus.busy), 1);
    chk("dense_fwd_dv", int'(bus.down_valid), 1);
    chk("dense_fwd_rd", int'(bus.right_data), 16);
    step(1, 0, 16, 1, 1, 0, 16, 1);
    chk("dense_fwd_di", int'(bus.down_idx), 1);
    step(1, 0, 16, 2, 1, 0, 16, 2);
    chk("dense_rv_early", int'(bus.result_valid), 0);
    step(1, 1, 16, 3, 1, 1, 16, 3);
    chk("dense_rv", int'(bus.result_valid), 1);
    chk("dense_result", sres(), 64);
    chk("dense_fwd_dl", int'(bus.down_last), 1);
    idle();
    chk("dense_rv_off", int'(bus.result_valid), 0);
    chk("dense_busy_off", int'(bus.busy), 0);
    chk("dense_hold", sres(), 64);
    chk("dense_fwd_rv0", int'(bus.right_valid), 0);

    // Sparse: up {1,4,6}, left {2,4,7}, 2.0 each; only 4 matches (via buffer)
    step(1, 0, 32, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32, 2);
    step(1, 0, 32, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32, 4);
    step(1, 1, 32, 6, 0, 0, 0, 0);
    chk("sparse_rv_early", int'(bus.result_valid), 0);
    step(0, 0, 0, 0, 1, 1, 32, 7);
    chk("sparse_rv", int'(bus.result_valid), 1);
    chk("sparse_result", sres(), 64);
    idle();

    // Saturation high: 8 pairs of 127 -> 127
    for (int i = 0; i < 8; i++) step(1, i == 7, 127, i, 1, i == 7, 127, i);
    chk("sat_hi_rv", int'(bus.result_valid), 1);
    chk("sat_hi", sres(), 127);
    idle();
    // Saturation low, back-to-back after a single gap: 127 * -128 -> -128
    for (int i = 0; i < 8; i++) step(1, i == 7, 127, i, 1, i == 7, -128, i);
    chk("sat_lo_rv", int'(bus.result_valid), 1);
    chk("sat_lo", sres(), -128);
    idle();
    chk("sat_lo_rv_off", int'(bus.result_valid), 0);

    // Floor shift: 1.0*3.0 = 48, then 1 * -1 = -1/256 -> floor -> -1; total 47
    step(1, 0, 16, 0, 1, 0, 48, 0);
    step(1, 1, 1, 1, 1, 1, -1, 1);
    chk("floor_result", sres(), 47);
    idle();

    // Overflow: up 0..5 into a 4-deep buffer, then left 5
    for (int i = 0; i < 6; i++) begin
      step(1, i == 5, 16, i, 0, 0, 0, 0);
      if (i == 3) chk("ovf_full_no_loss", int'(bus.overflow), 0);
      if (i == 4) chk("ovf_set", int'(bus.overflow), 1);
    end
    step(0, 0, 0, 0, 1, 1, 16, 5);
    chk("ovf_rv", int'(bus.result_valid), 1);
    chk("ovf_result", sres(), 16);
    idle();
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Reset mid-operation abandons it
    step(1, 0, 16, 0, 1, 0, 16, 0);
    rst = 1'b1;
    step(1, 1, 16, 1, 1, 1, 16, 1);
    chk("midrst_rv", int'(bus.result_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_ovf", int'(bus.overflow), 0);
    chk("midrst_result", sres(), 0);
    chk("midrst_dv", int'(bus.down_valid), 0);
    rst = 1'b0;
    step(1, 0, 16, 0, 1, 0, 16, 0);
    step(1, 1, 16, 1, 1, 1, 16, 1);
    chk("postrst_rv", int'(bus.result_valid), 1);
    chk("postrst_result", sres(), 32);
    idle();
    chk("postrst_rv_off", int'(bus.result_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
